// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified I/D memory port arbiter.
// FSM state encodings, port identifiers and default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_XLEN   = 32;
  localparam int WDOG_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Transaction watchdog: counts BUSY cycles without an ack.
// Raises expire on the last allowed cycle and keeps a sticky bus error.
module mem_port_arbiter_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expire,
  output logic bus_err
);

  logic [WDOG_W-1:0] wdog;

  // wdog holds the number of BUSY cycles already spent, so the abort
  // happens after exactly TIMEOUT unacknowledged BUSY cycles.
  assign expire = busy && !ack && (wdog == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog    <= '0;
      bus_err <= 1'b0;
    end else begin
      if (start) begin
        wdog <= '0;
      end else if (busy && !ack && !expire) begin
        wdog <= wdog + 1'b1;
      end
      if (expire) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between fetch (I) and memory stage (D).
// D has priority, bounded by a streak limit so a pending fetch is not starved.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int XLEN         = DEF_XLEN,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN/8-1:0] d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_ready,
  output logic [XLEN-1:0]   d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic              stall_f,
  output logic              stall_m,
  output logic              bus_err
);

  arb_state_t state;
  logic [3:0] streak;
  logic       i_elig;
  logic       d_elig;
  logic       busy;
  logic       grant_valid;
  port_t      grant_port;
  logic       wd_expire;

  // A requester whose ready is high this cycle is retiring, not asking again.
  assign i_elig  = i_req && !i_ready;
  assign d_elig  = d_req && !d_ready;
  assign busy    = (state != ST_IDLE);
  assign stall_f = i_req && !i_ready;
  assign stall_m = d_req && !d_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = PORT_I;
    if (state == ST_IDLE) begin
      if (d_elig && (!i_elig || (int'(streak) < MAX_D_STREAK))) begin
        grant_valid = 1'b1;
        grant_port  = PORT_D;
      end else if (i_elig) begin
        grant_valid = 1'b1;
      end
    end
  end

  mem_port_arbiter_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .start  (grant_valid),
    .busy   (busy),
    .ack    (mem_ack),
    .expire (wd_expire),
    .bus_err(bus_err)
  );

  // A timed-out transaction still retires with a ready pulse and zero data
  // so the pipeline drains instead of hanging.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            mem_req <= 1'b1;
            if (grant_port == PORT_D) begin
              state     <= ST_BUSY_D;
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              streak    <= i_elig ? streak + 4'd1 : 4'd0;
            end else begin
              state    <= ST_BUSY_I;
              mem_we   <= 1'b0;
              mem_be   <= '1;
              mem_addr <= i_addr;
              streak   <= 4'd0;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (mem_ack || wd_expire) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            if (state == ST_BUSY_I) begin
              i_ready <= 1'b1;
              i_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_ready <= 1'b1;
              if (!mem_ack) begin
                d_rdata <= '0;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int XLEN         = 32;
  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_f;
  logic        stall_m;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .XLEN(XLEN), .MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dop_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model: who owns the memory, how long it has waited, and
  // what each registered output should show.
  int          m_owner;
  int          m_waited;
  int          m_streak;
  logic        m_mem_req, m_mem_we, m_i_ready, m_d_ready, m_bus_err;
  logic [3:0]  m_mem_be;
  logic [31:0] m_mem_addr, m_mem_wdata, m_i_rdata, m_d_rdata;

  logic [31:0] iq[$];
  dop_t        dq[$];
  int          ack_mode;
  int          cur_delay;
  logic        rd_override_en;
  logic [31:0] rd_override;
  logic        spurious_en;
  logic        rst_req;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic modelReset();
    m_owner = 0; m_waited = 0; m_streak = 0;
    m_mem_req = 0; m_mem_we = 0; m_i_ready = 0; m_d_ready = 0; m_bus_err = 0;
    m_mem_be = 0; m_mem_addr = 0; m_mem_wdata = 0; m_i_rdata = 0; m_d_rdata = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: compare registered outputs, drive requesters and memory,
  // check the combinational stalls, then advance the model.
  task automatic applyStimulus();
    logic i_el, d_el;
    dop_t d;
    @(posedge clk); #1; cyc++;
    checkOutput("mem_req",   32'(mem_req),   32'(m_mem_req));
    checkOutput("mem_we",    32'(mem_we),    32'(m_mem_we));
    checkOutput("mem_be",    32'(mem_be),    32'(m_mem_be));
    checkOutput("mem_addr",  mem_addr,       m_mem_addr);
    checkOutput("mem_wdata", mem_wdata,      m_mem_wdata);
    checkOutput("i_ready",   32'(i_ready),   32'(m_i_ready));
    checkOutput("d_ready",   32'(d_ready),   32'(m_d_ready));
    checkOutput("i_rdata",   i_rdata,        m_i_rdata);
    checkOutput("d_rdata",   d_rdata,        m_d_rdata);
    checkOutput("bus_err",   32'(bus_err),   32'(m_bus_err));

    if (m_i_ready && iq.size() > 0) void'(iq.pop_front());
    if (m_d_ready && dq.size() > 0) void'(dq.pop_front());
    i_req  = (iq.size() > 0);
    i_addr = i_req ? iq[0] : 32'h0;
    if (dq.size() > 0) begin
      d = dq[0];
      d_req = 1'b1; d_we = d.we; d_be = d.be; d_addr = d.addr; d_wdata = d.wdata;
    end else begin
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    end
    reset   = rst_req;
    rst_req = 1'b0;

    if (m_owner != 0) begin
      if (m_waited == 0) begin
        if (ack_mode == -2)
          cur_delay = ($urandom_range(0, 15) == 0) ? 99 : int'($urandom_range(0, 3));
        else
          cur_delay = ack_mode;
      end
      mem_ack   = (m_waited == cur_delay);
      mem_rdata = mem_ack ? (rd_override_en ? rd_override : memfn(m_mem_addr)) : $urandom();
    end else begin
      mem_ack   = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom();
    end

    #1;
    checkOutput("stall_f", 32'(stall_f), 32'(i_req && !m_i_ready));
    checkOutput("stall_m", 32'(stall_m), 32'(d_req && !m_d_ready));

    i_el = i_req && !m_i_ready;
    d_el = d_req && !m_d_ready;
    if (reset) begin
      modelReset();
    end else begin
      m_i_ready = 0;
      m_d_ready = 0;
      if (m_owner == 0) begin
        if (d_el && (!i_el || m_streak < MAX_D_STREAK)) begin
          m_owner = 2; m_waited = 0; m_mem_req = 1;
          m_mem_we = d_we; m_mem_be = d_be; m_mem_addr = d_addr; m_mem_wdata = d_wdata;
          m_streak = i_el ? m_streak + 1 : 0;
        end else if (i_el) begin
          m_owner = 1; m_waited = 0; m_mem_req = 1;
          m_mem_we = 0; m_mem_be = 4'hF; m_mem_addr = i_addr;
          m_streak = 0;
        end
      end else if (mem_ack || (m_waited + 1 == TIMEOUT)) begin
        if (!mem_ack) m_bus_err = 1;
        if (m_owner == 1) begin
          m_i_ready = 1;
          m_i_rdata = mem_ack ? mem_rdata : 32'h0;
        end else begin
          m_d_ready = 1;
          if (!mem_ack) m_d_rdata = 32'h0;
          else if (!m_mem_we) m_d_rdata = mem_rdata;
        end
        m_owner = 0; m_mem_req = 0;
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic drain(input string tag, input int limit);
    int k;
    k = 0;
    while ((iq.size() > 0 || dq.size() > 0 || m_owner != 0) && k < limit) begin
      applyStimulus();
      k++;
    end
    applyStimulus();
    checkOutput({tag, "_drained"}, 32'(k < limit), 32'd1);
  endtask

  initial begin
    int start;
    int at;
    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0;
    d_addr = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    modelReset();
    ack_mode = 0; cur_delay = 0; rd_override_en = 0; rd_override = 0;
    spurious_en = 0; rst_req = 1'b1;

    applyStimulus();
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    applyStimulus();
    applyStimulus();

    $display("[TB] I-only fetch");
    ack_mode = 0; rd_override_en = 1; rd_override = 32'h0050_0093;
    iq.push_back(32'h0000_0100);
    start = cyc + 1;
    at = -1;
    for (int k = 0; k < 20 && at < 0; k++) begin
      applyStimulus();
      if (i_ready === 1'b1) at = cyc;
    end
    checkOutput("ionly_latency", 32'(at), 32'(start + 2));
    checkOutput("ionly_rdata", i_rdata, 32'h0050_0093);
    drain("ionly", 10);

    $display("[TB] wait states");
    ack_mode = 5; rd_override = 32'hDEAD_BEEF;
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_3000, wdata: 32'h0});
    applyStimulus();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus();
      checkOutput("ws_mem_req", 32'(mem_req), 32'd1);
      checkOutput("ws_mem_addr", mem_addr, 32'h0000_3000);
      checkOutput("ws_no_ready", 32'(d_ready), 32'd0);
    end
    applyStimulus();
    checkOutput("ws_d_ready", 32'(d_ready), 32'd1);
    checkOutput("ws_d_rdata", d_rdata, 32'hDEAD_BEEF);
    checkOutput("ws_req_low", 32'(mem_req), 32'd0);
    drain("ws", 10);

    $display("[TB] simultaneous requests");
    ack_mode = 0; rd_override_en = 0;
    dq.push_back('{we: 1'b1, be: 4'b0011, addr: 32'h0000_2000, wdata: 32'hCAFE_0001});
    iq.push_back(32'h0000_0104);
    applyStimulus();
    applyStimulus();
    checkOutput("sim_d_first_we", 32'(mem_we), 32'd1);
    checkOutput("sim_d_first_be", 32'(mem_be), 32'h3);
    checkOutput("sim_d_first_addr", mem_addr, 32'h0000_2000);
    applyStimulus();
    checkOutput("sim_d_ready", 32'(d_ready), 32'd1);
    checkOutput("sim_d_rdata_kept", d_rdata, 32'hDEAD_BEEF);
    applyStimulus();
    checkOutput("sim_i_issued", 32'(mem_req), 32'd1);
    checkOutput("sim_i_addr", mem_addr, 32'h0000_0104);
    checkOutput("sim_i_we", 32'(mem_we), 32'd0);
    applyStimulus();
    checkOutput("sim_i_ready", 32'(i_ready), 32'd1);
    checkOutput("sim_i_rdata", i_rdata, memfn(32'h0000_0104));
    drain("sim", 10);

    $display("[TB] starvation guard");
    for (int k = 0; k < 6; k++)
      dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h4000 + 32'(4 * k), wdata: 32'h0});
    iq.push_back(32'h0000_0200);
    iq.push_back(32'h0000_0204);
    drain("starve", 80);

    $display("[TB] timeout");
    ack_mode = -1;
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_5000, wdata: 32'h0});
    applyStimulus();
    for (int k = 1; k <= TIMEOUT; k++) begin
      applyStimulus();
      checkOutput("to_busy", 32'(mem_req), 32'd1);
    end
    applyStimulus();
    checkOutput("to_req_drop", 32'(mem_req), 32'd0);
    checkOutput("to_bus_err", 32'(bus_err), 32'd1);
    checkOutput("to_d_ready", 32'(d_ready), 32'd1);
    checkOutput("to_d_rdata", d_rdata, 32'h0);
    ack_mode = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      checkOutput("to_sticky", 32'(bus_err), 32'd1);
    end
    drain("to", 10);

    $display("[TB] reset mid BUSY_D");
    ack_mode = 5;
    dq.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_6000, wdata: 32'h0});
    applyStimulus();
    applyStimulus();
    applyStimulus();
    rst_req = 1'b1;
    applyStimulus();
    ack_mode = 0;
    applyStimulus();
    checkOutput("rstb_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rstb_no_ready", 32'(d_ready), 32'd0);
    checkOutput("rstb_bus_err", 32'(bus_err), 32'd0);
    drain("rstb", 10);

    $display("[TB] randomized traffic");
    ack_mode = -2; spurious_en = 1;
    for (int k = 0; k < 600; k++) begin
      if (iq.size() < 2 && $urandom_range(0, 2) == 0)
        iq.push_back({$urandom_range(0, 255), 2'b00} + 32'h1000);
      if (dq.size() < 2 && $urandom_range(0, 2) == 0)
        dq.push_back('{we: 1'($urandom_range(0, 1)), be: 4'($urandom_range(0, 15)),
                       addr: $urandom(), wdata: $urandom()});
      if ($urandom_range(0, 149) == 0) rst_req = 1'b1;
      applyStimulus();
    end
    spurious_en = 0; ack_mode = 0;
    drain("rand", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
